// File: rtl/pueo_prog_beamformer.sv
// Run-time programmable delay-and-sum beamformer: per-beam channel delays, power
// per clock, threshold trigger with holdoff, and shadowed configuration with settle.
module pueo_prog_beamformer #(
    parameter int NUM_BEAMS   = 2,
    parameter int NCHAN       = 4,
    parameter int NSAMP       = 8,
    parameter int SAMPLE_BITS = 5,
    parameter int DELAY_DEPTH = 4,
    parameter int HOLDOFF     = 16,
    localparam int BW = (NUM_BEAMS > 1) ? $clog2(NUM_BEAMS) : 1,
    localparam int IW = $clog2(NCHAN + 1),
    localparam int SW = SAMPLE_BITS + $clog2(NCHAN),
    localparam int PW = 2*SW + $clog2(NSAMP)
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic [NCHAN*NSAMP*SAMPLE_BITS-1:0]  dat_i,
    input  logic [NUM_BEAMS-1:0]                beam_mask_i,
    input  logic                                cfg_wr_i,
    input  logic [BW-1:0]                       cfg_beam_i,
    input  logic [IW-1:0]                       cfg_idx_i,
    input  logic [31:0]                         cfg_data_i,
    input  logic                                cfg_update_i,
    output logic                                settling_o,
    output logic [NUM_BEAMS-1:0]                trig_o,
    output logic [NUM_BEAMS*PW-1:0]             power_o
);
    localparam int DW  = (DELAY_DEPTH > 1) ? $clog2(DELAY_DEPTH) : 1;
    localparam int CIW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int HW  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam int CW  = $clog2(DELAY_DEPTH + 5);
    localparam int QW  = 2*SW;

    typedef enum logic {IDLE, SETTLE} state_t;

    logic [NCHAN-1:0][NSAMP-1:0][SAMPLE_BITS-1:0]                   din;
    logic [DELAY_DEPTH-1:0][NCHAN-1:0][NSAMP-1:0][SAMPLE_BITS-1:0]  dly;
    logic [NUM_BEAMS-1:0][NCHAN-1:0][NSAMP-1:0][SAMPLE_BITS-1:0]    tap;
    logic [NUM_BEAMS-1:0][NSAMP-1:0][SW-1:0]                        sum_d, sum_q;
    logic [NUM_BEAMS-1:0][PW-1:0]                                   pow_d, power_q;
    logic [NUM_BEAMS-1:0][NCHAN-1:0][DW-1:0]                        dly_sh, dly_sh_d, dly_act;
    logic [NUM_BEAMS-1:0][PW-1:0]                                   thr_sh, thr_sh_d, thr_act;
    logic [NUM_BEAMS-1:0][HW-1:0]                                   hold;
    logic [NUM_BEAMS-1:0]                                           fire, trig_q;
    logic [31:0]                                                    beam_ext, idx_ext;
    logic [DW-1:0]                                                  dly_clamp;
    state_t                                                         state, state_d;
    logic [CW-1:0]                                                  scnt, scnt_d;

    assign din      = dat_i;
    assign beam_ext = 32'(cfg_beam_i);
    assign idx_ext  = 32'(cfg_idx_i);
    assign dly_clamp = (cfg_data_i > 32'(DELAY_DEPTH - 1)) ? DW'(DELAY_DEPTH - 1)
                                                          : cfg_data_i[DW-1:0];

    // Shadow next-value is also what a same-cycle commit copies to the active set.
    always_comb begin
        dly_sh_d = dly_sh;
        thr_sh_d = thr_sh;
        if (cfg_wr_i && beam_ext < NUM_BEAMS) begin
            if (idx_ext < NCHAN)
                dly_sh_d[cfg_beam_i][cfg_idx_i[CIW-1:0]] = dly_clamp;
            else if (idx_ext == NCHAN)
                thr_sh_d[cfg_beam_i] = cfg_data_i[PW-1:0];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            dly_sh  <= '0;
            thr_sh  <= '1;
            dly_act <= '0;
            thr_act <= '1;
        end else begin
            dly_sh <= dly_sh_d;
            thr_sh <= thr_sh_d;
            if (cfg_update_i) begin
                dly_act <= dly_sh_d;
                thr_act <= thr_sh_d;
            end
        end
    end

    always_comb begin
        state_d = state;
        scnt_d  = scnt;
        if (cfg_update_i) begin
            state_d = SETTLE;
            scnt_d  = CW'(DELAY_DEPTH + 4);
        end else if (state == SETTLE) begin
            if (scnt <= CW'(1)) begin
                state_d = IDLE;
                scnt_d  = '0;
            end else begin
                scnt_d = scnt - CW'(1);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
            scnt  <= '0;
        end else begin
            state <= state_d;
            scnt  <= scnt_d;
        end
    end

    always_comb begin : p_sum
        logic signed [SW-1:0] acc;
        acc   = '0;
        sum_d = '0;
        for (int b = 0; b < NUM_BEAMS; b++) begin
            for (int s = 0; s < NSAMP; s++) begin
                acc = '0;
                for (int c = 0; c < NCHAN; c++)
                    acc = acc + SW'($signed(tap[b][c][s]));
                sum_d[b][s] = acc;
            end
        end
    end

    // Squares are non-negative and fit QW bits, so the product is taken unsigned.
    always_comb begin : p_pow
        logic signed [QW-1:0] se;
        logic [PW-1:0]        acc;
        se    = '0;
        acc   = '0;
        pow_d = '0;
        for (int b = 0; b < NUM_BEAMS; b++) begin
            acc = '0;
            for (int s = 0; s < NSAMP; s++) begin
                se  = QW'($signed(sum_q[b][s]));
                acc = acc + PW'($unsigned(se * se));
            end
            pow_d[b] = acc;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            dly     <= '0;
            tap     <= '0;
            sum_q   <= '0;
            power_q <= '0;
        end else begin
            dly[0] <= din;
            for (int k = 1; k < DELAY_DEPTH; k++)
                dly[k] <= dly[k-1];
            for (int b = 0; b < NUM_BEAMS; b++)
                for (int c = 0; c < NCHAN; c++)
                    tap[b][c] <= dly[dly_act[b][c]][c];
            sum_q   <= sum_d;
            power_q <= pow_d;
        end
    end

    always_comb begin
        fire = '0;
        for (int b = 0; b < NUM_BEAMS; b++)
            fire[b] = (power_q[b] > thr_act[b]) && !beam_mask_i[b] &&
                      (hold[b] == '0) && (state == IDLE);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            trig_q <= '0;
            hold   <= '0;
        end else begin
            trig_q <= fire;
            for (int b = 0; b < NUM_BEAMS; b++) begin
                if (fire[b])
                    hold[b] <= HW'(HOLDOFF);
                else if (hold[b] != '0)
                    hold[b] <= hold[b] - HW'(1);
            end
        end
    end

    assign trig_o     = trig_q;
    assign power_o    = power_q;
    assign settling_o = (state == SETTLE);

endmodule

// File: tb/tb_pueo_prog_beamformer.sv
// Directed bench for pueo_prog_beamformer: power table, delay/clamp timing,
// shadowing and settle, holdoff, masking, and mid-run reset.
module tb_pueo_prog_beamformer;
    localparam int NB = 2, NC = 4, NS = 8, SB = 5, DD = 4, HO = 16;
    localparam int SW = SB + $clog2(NC);
    localparam int PW = 2*SW + $clog2(NS);
    localparam int DATW = NC*NS*SB;

    logic              aclk;
    logic              aresetn;
    logic [DATW-1:0]   dat;
    logic [NB-1:0]     mask;
    logic              cfg_wr;
    logic [0:0]        cfg_beam;
    logic [2:0]        cfg_idx;
    logic [31:0]       cfg_data;
    logic              cfg_update;
    logic              settling;
    logic [NB-1:0]     trig;
    logic [NB*PW-1:0]  power;

    pueo_prog_beamformer #(
        .NUM_BEAMS(NB), .NCHAN(NC), .NSAMP(NS), .SAMPLE_BITS(SB),
        .DELAY_DEPTH(DD), .HOLDOFF(HO)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .dat_i(dat), .beam_mask_i(mask),
        .cfg_wr_i(cfg_wr), .cfg_beam_i(cfg_beam), .cfg_idx_i(cfg_idx),
        .cfg_data_i(cfg_data), .cfg_update_i(cfg_update),
        .settling_o(settling), .trig_o(trig), .power_o(power)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        int c0; int c1; int c2; int c3;
        int exp_pw;
    } vec_t;
    vec_t vecs[9];

    int n_checks = 0;
    int n_err    = 0;
    int p0[12], p1[12], t0[12], t1[12];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic int pw(input int b);
        return int'(power[b*PW +: PW]);
    endfunction

    function automatic logic [DATW-1:0] mk(input int c0, input int c1, input int c2, input int c3);
        int v[4];
        logic [DATW-1:0] d;
        v = '{c0, c1, c2, c3};
        d = '0;
        for (int c = 0; c < NC; c++)
            for (int s = 0; s < NS; s++)
                d[(c*NS+s)*SB +: SB] = SB'(v[c]);
        return d;
    endfunction

    task automatic cfg_write(input int b, input int idx, input int data, input bit upd);
        cfg_wr = 1'b1; cfg_beam = 1'(b); cfg_idx = 3'(idx); cfg_data = 32'(data);
        cfg_update = upd;
        tick();
        cfg_wr = 1'b0; cfg_update = 1'b0;
    endtask

    task automatic commit();
        cfg_update = 1'b1;
        tick();
        cfg_update = 1'b0;
    endtask

    task automatic wait_settle(input string name);
        int n;
        n = 0;
        while (settling && n < 50) begin
            tick();
            n++;
        end
        check(name, int'(settling), 0);
    endtask

    task automatic apply_reset();
        aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
    endtask

    // One clock of the given pattern at edge N, then zeros; index k = edge N+k.
    task automatic impulse(input int c0, input int c1, input int c2, input int c3);
        dat = mk(c0, c1, c2, c3);
        tick();
        dat = '0;
        p0[0] = 0; p1[0] = 0; t0[0] = 0; t1[0] = 0;
        for (int k = 1; k < 12; k++) begin
            tick();
            p0[k] = pw(0); p1[k] = pw(1);
            t0[k] = int'(trig[0]); t1[k] = int'(trig[1]);
        end
    endtask

    function automatic int total(input int a[12]);
        int s;
        s = 0;
        for (int k = 0; k < 12; k++) s += a[k];
        return s;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        int n, c0n, c1n;
        int q[$];

        aresetn = 1'b0; dat = '0; mask = '0; cfg_wr = 1'b0; cfg_beam = '0;
        cfg_idx = '0; cfg_data = '0; cfg_update = 1'b0;

        vecs[0] = '{  1,   1,   1,   1,   128};
        vecs[1] = '{-16, -16, -16, -16, 32768};
        vecs[2] = '{ 15,  15,  15,  15, 28800};
        vecs[3] = '{ 15,   0,   0,   0,  1800};
        vecs[4] = '{  3,  -2,   5,  -7,     8};
        vecs[5] = '{  0,   0,   0,   0,     0};
        vecs[6] = '{ 15,  15, -16, -16,    32};
        vecs[7] = '{ -1,  -1,  -1,  -1,   128};
        vecs[8] = '{-16,  15, -16,   0,  2312};

        #12;
        check("rst_trig", int'(trig), 0);
        check("rst_power0", pw(0), 0);
        check("rst_power1", pw(1), 0);
        check("rst_settling", int'(settling), 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;

        // Threshold 127 under power 128: fires with period HOLDOFF+1
        dat = mk(1, 1, 1, 1);
        cfg_write(0, 4, 127, 1'b0);
        cfg_write(1, 4, 127, 1'b0);
        commit();
        n = 0;
        while (settling && n < 50) begin
            n++;
            tick();
        end
        check("settle_len", n, 8);
        c1n = 0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (trig[0]) q.push_back(k);
            c1n += int'(trig[1]);
        end
        check("t127_power0", pw(0), 128);
        check("t127_power1", pw(1), 128);
        check("t127_npulse0", q.size(), 4);
        check("t127_npulse1", c1n, 4);
        if (q.size() >= 3) begin
            check("t127_first", q[0], 1);
            check("t127_gap1", q[1] - q[0], 17);
            check("t127_gap2", q[2] - q[1], 17);
        end

        // Threshold 128 equal to power: strict compare never fires
        cfg_write(0, 4, 128, 1'b0);
        cfg_write(1, 4, 128, 1'b0);
        commit();
        wait_settle("t128_settle");
        n = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            n += int'(trig != '0);
        end
        check("t128_notrig", n, 0);
        check("t128_power0", pw(0), 128);

        for (int i = 0; i < 9; i++) begin
            dat = mk(vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].c3);
            repeat (4) tick();
            check($sformatf("vec%0d_power0", i), pw(0), vecs[i].exp_pw);
            check($sformatf("vec%0d_power1", i), pw(1), vecs[i].exp_pw);
        end

        // Beam 1 ch0 delay 2, threshold 1000
        apply_reset();
        dat = '0;
        cfg_write(1, 0, 2, 1'b0);
        cfg_write(1, 4, 1000, 1'b0);
        commit();
        wait_settle("dly_settle");
        repeat (4) tick();
        impulse(15, 0, 0, 0);
        check("dly_b1_pow_n4", p1[4], 0);
        check("dly_b1_pow_n5", p1[5], 1800);
        check("dly_b1_pow_n6", p1[6], 0);
        check("dly_b0_pow_n3", p0[3], 1800);
        check("dly_b1_trig_n6", t1[6], 1);
        check("dly_b1_trig_cnt", total(t1), 1);
        check("dly_b0_trig_cnt", total(t0), 0);

        // Delay 7 clamps to 3; threshold write lands with the commit
        cfg_write(0, 1, 7, 1'b0);
        cfg_write(0, 4, 1000, 1'b1);
        wait_settle("clamp_settle");
        repeat (4) tick();
        impulse(0, 15, 0, 0);
        check("clamp_b0_pow_n5", p0[5], 0);
        check("clamp_b0_pow_n6", p0[6], 1800);
        check("clamp_b0_trig_n7", t0[7], 1);
        check("clamp_b0_trig_cnt", total(t0), 1);
        check("clamp_b1_pow_n3", p1[3], 1800);
        check("clamp_b1_trig_n4", t1[4], 1);

        // Shadow writes have no effect until commit; bad index ignored
        apply_reset();
        dat = mk(1, 1, 1, 1);
        cfg_write(0, 4, 100, 1'b0);
        cfg_write(1, 4, 100, 1'b0);
        cfg_write(0, 5, 5000, 1'b0);
        n = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            n += int'(trig != '0);
        end
        check("shadow_notrig", n, 0);
        commit();
        for (int k = 1; k < 12; k++) begin
            tick();
            t0[k] = int'(trig[0]);
            t1[k] = int'(trig[1]);
        end
        n = 0;
        for (int k = 1; k <= 8; k++) n += t0[k] + t1[k];
        check("settle_suppress", n, 0);
        check("settle_b0_fire", t0[9], 1);
        check("settle_b1_fire", t1[9], 1);

        // Mask beam 0 only
        mask = 2'b01;
        c0n = 0; c1n = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            c0n += int'(trig[0]);
            c1n += int'(trig[1]);
        end
        check("mask_b0_silent", c0n, 0);
        check("mask_b1_fires", int'(c1n >= 2), 1);
        mask = 2'b00;
        tick();
        check("unmask_b0_fire", int'(trig[0]), 1);

        // Extremes, then asynchronous reset while settling
        dat = mk(-16, -16, -16, -16);
        repeat (4) tick();
        check("ext_power0", pw(0), 32768);
        check("ext_power1", pw(1), 32768);
        commit();
        tick();
        #2;
        aresetn = 1'b0;
        #1;
        check("midrst_trig", int'(trig), 0);
        check("midrst_power0", pw(0), 0);
        check("midrst_power1", pw(1), 0);
        check("midrst_settling", int'(settling), 0);
        tick();
        tick();
        aresetn = 1'b1;
        commit();
        wait_settle("midrst_settle");
        n = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            n += int'(trig != '0);
        end
        check("midrst_thr_allones", n, 0);
        check("midrst_power0_after", pw(0), 32768);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/pueo_prog_beamformer.md
# pueo_prog_beamformer

Parametrised, run-time-programmable successor to the fixed dummy-beam set. It takes NCHAN channels of NSAMP signed samples per clock and forms NUM_BEAMS beams. Each beam has a programmable per-channel whole-clock delay, a channel sum, a squared-power accumulation per clock and a programmable threshold. It produces one trigger bit per beam, with holdoff. It sits between the sample-store/alignment front end and the trigger collection logic, replacing the compile-time beam tables with shadowed configuration registers.

## Interface
Parameters:
- NUM_BEAMS, 2, number of beams formed.
- NCHAN, 4, channels per beam; every beam uses all channels.
- NSAMP, 8, samples per channel per clock.
- SAMPLE_BITS, 5, signed input sample width.
- DELAY_DEPTH, 4, delay-line depth in clocks. The legal per-channel delay range is 0..DELAY_DEPTH-1.
- HOLDOFF, 16, number of clocks a beam stays suppressed after it fires.

Derived widths:
- SW = SAMPLE_BITS + clog2(NCHAN)
- PW = 2*SW + clog2(NSAMP); defaults give SW = 7, PW = 17.

Ports:
- aclk, in, 1: the single clock.
- aresetn, in, 1: asynchronous, active-low reset.
- dat_i, in, NCHAN*NSAMP*SAMPLE_BITS: samples. Channel c, sample s sits at bit offset (c*NSAMP+s)*SAMPLE_BITS. Sample 0 is the earliest.
- beam_mask_i, in, NUM_BEAMS: 1 = beam b is masked; its trig_o stays 0.
- cfg_wr_i, in, 1: one-cycle write strobe to the shadow registers.
- cfg_beam_i, in, clog2(NUM_BEAMS): beam being written.
- cfg_idx_i, in, clog2(NCHAN+1): field select. Values 0..NCHAN-1 select a channel delay; NCHAN selects the threshold.
- cfg_data_i, in, 32: write data. Delays use bits [clog2(DELAY_DEPTH)-1:0]; the threshold uses [PW-1:0].
- cfg_update_i, in, 1: one-cycle strobe that commits all shadow registers to the active registers.
- settling_o, out, 1: high while the pipeline is flushing after a commit.
- trig_o, out, NUM_BEAMS: one-cycle trigger pulse per beam.
- power_o, out, NUM_BEAMS*PW: registered per-clock power of each beam, for monitoring.

## Operation
Configuration:
- Writes land in shadow registers only.
- Delay values greater than DELAY_DEPTH-1 are clamped to DELAY_DEPTH-1 at write.
- Writes with cfg_idx_i > NCHAN, or cfg_beam_i >= NUM_BEAMS, are ignored.
- cfg_update_i copies every shadow register to the active set in one cycle. If cfg_wr_i and cfg_update_i occur in the same cycle, the write lands in the shadow first and is included in the commit.
- Reset values: delays 0; thresholds all-ones, so no beam triggers until a threshold is programmed.

Datapath, per channel:
- Shift-register delay line, slot 0 to slot DELAY_DEPTH-1. Slot k holds the input from k clocks earlier.

Datapath, per beam and per clock:
1. Tap register: selects slot delay[b][c] for every channel c.
2. Sum: for each sample s, sum over channels, sign-extended to SW bits.
3. Square: each sum is squared, unsigned, 2*SW bits.
4. Power: the NSAMP squares are summed into a PW-bit value, which is registered to power_o. No overflow is possible at these widths.
5. Compare: fires when power > threshold (strict) and all of the following hold:
   - beam not masked;
   - holdoff counter is 0;
   - settling_o is low.

Trigger and holdoff:
- On fire, trig_o[b] is 1 for exactly one cycle and the holdoff counter loads HOLDOFF.
- The counter decrements each clock to 0. Fires are blocked while it is nonzero.
- With HOLDOFF = 0 a beam may fire every clock.

Settle state machine:
- States IDLE and SETTLE.
- cfg_update_i moves the machine to SETTLE and loads the settle counter with DELAY_DEPTH+4.
- In SETTLE the counter decrements to 0, then the machine returns to IDLE.
- A new cfg_update_i while in SETTLE reloads the counter.
- settling_o = (state == SETTLE).
- Holdoff counters keep running during SETTLE.

## Timing
- An input captured at edge N, with active delay d on a channel, contributes to power_o registered at edge N+d+3. The matching trig_o is registered at edge N+d+4.
- Commit: the active registers change at the edge that samples cfg_update_i. settling_o is high from the next cycle for DELAY_DEPTH+4 cycles.
- Reset, asynchronous assert:
  - trig_o = 0, power_o = 0, settling_o = 0;
  - delay lines and pipeline registers cleared; holdoff counters 0; state IDLE;
  - shadow and active registers at their reset values.
- Reset mid-operation discards pending triggers and configuration.
- The first valid power_o after reset release is at edge 4; before that it reflects zeroed pipeline contents.
- beam_mask_i is sampled at the compare stage. A masked fire does not load holdoff.

## Test plan
- Reset, then drive all samples = 1 with delays 0, program thresholds 127 and commit. After settling: power_o = 128 on both beams and trig_o pulses every 17 clocks (HOLDOFF 16). With threshold 128: power_o = 128, trig_o never asserts.
- Beam 1: ch0 delay 2, others 0, threshold 1000, commit, wait for settling. One clock with ch0 = 15 in all samples, others 0, at edge N. Beam 1 power_o = 1800 at edge N+5; trig_o[1] at N+6 only; beam 0 stays at threshold all-ones, so no trigger.
- Write delay 7 to beam 0 ch1 (DELAY_DEPTH 4), commit. The active delay reads as 3, verified by impulse timing at N+3+4.
- Shadowing: write a threshold without commit; power above it must not trigger. Commit: trig_o is suppressed for the 8 cycles of settling_o, then fires.
- Mask beam 0 mid-stream: trig_o[0] goes to 0 at once while beam 1 continues. Unmask: beam 0 fires on the next over-threshold clock, with no holdoff carried over.
- Extremes: all samples -16, delays 0. Per sample: sum = -64, square = 4096, power = 32768, with no overflow. Assert aresetn mid-run: all outputs go to 0 immediately and thresholds return to all-ones.
